// File: rtl/closed_list_writer_if.sv
// Insert handshake, clear control, status and random-access read port
// shared between the closed-list writer and its clients.
interface closed_list_writer_if #(
  parameter int CW   = 8,
  parameter int IDXW = 9
);
  logic            ins_valid;
  logic [CW-1:0]   ins_x;
  logic [CW-1:0]   ins_y;
  logic            ins_ready;
  logic            ins_done;
  logic            clear;
  logic            busy;
  logic [IDXW-1:0] rd_index;
  logic [CW-1:0]   rd_x;
  logic [CW-1:0]   rd_y;
  logic [IDXW-1:0] count;
  logic            full;
  logic            overflow;

  modport master (
    output ins_valid, ins_x, ins_y, clear, rd_index,
    input  ins_ready, ins_done, busy, rd_x, rd_y, count, full, overflow
  );

  modport slave (
    input  ins_valid, ins_x, ins_y, clear, rd_index,
    output ins_ready, ins_done, busy, rd_x, rd_y, count, full, overflow
  );
endinterface

// File: rtl/closed_list_writer.sv
// A* closed-list store: appends expanded nodes, sweeps every entry to the
// 0xFF/0xFF sentinel after reset or on clear, and serves a registered read port.
module closed_list_writer #(
  parameter int DEPTH = 400,
  parameter int CW    = 8,
  parameter int IDXW  = 9
) (
  input  logic                Clk,
  input  logic                Reset,
  closed_list_writer_if.slave bus
);
  localparam logic [IDXW-1:0] DEPTH_I = IDXW'(DEPTH);
  localparam logic [IDXW-1:0] LAST_I  = IDXW'(DEPTH - 1);
  localparam logic [IDXW-1:0] ONE_I   = IDXW'(1);

  typedef enum logic [1:0] {SWEEP, IDLE, WRITE} state_t;

  state_t          state, state_nx;
  logic [IDXW-1:0] sweep_idx;
  logic [IDXW-1:0] count_q;
  logic            overflow_q;
  logic            ins_done_q;
  logic            full_w;
  logic            ins_ready_w;
  logic            busy_w;
  logic [CW-1:0]   cap_x, cap_y;
  logic [CW-1:0]   rd_x_q, rd_y_q;

  logic [CW-1:0]   mem_x [DEPTH];
  logic [CW-1:0]   mem_y [DEPTH];
  logic            mem_we;
  logic [IDXW-1:0] mem_waddr;
  logic [CW-1:0]   mem_wx, mem_wy;

  assign full_w = (count_q == DEPTH_I);

  always_ff @(posedge Clk) begin
    if (Reset) state <= SWEEP;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SWEEP:   if (sweep_idx == LAST_I) state_nx = IDLE;
      IDLE: begin
        if (bus.clear)                       state_nx = SWEEP;
        else if (bus.ins_valid && !full_w)   state_nx = WRITE;
      end
      WRITE:   state_nx = IDLE;
      default: state_nx = SWEEP;
    endcase
  end

  // Reset gates the write port so an insert in flight is dropped outright.
  always_comb begin
    ins_ready_w = (state == IDLE) && !full_w && !bus.clear;
    busy_w      = (state != IDLE);
    mem_we      = !Reset && ((state == SWEEP) || (state == WRITE));
    mem_waddr   = (state == SWEEP) ? sweep_idx : count_q;
    mem_wx      = (state == SWEEP) ? '1 : cap_x;
    mem_wy      = (state == SWEEP) ? '1 : cap_y;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sweep_idx  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ins_done_q <= 1'b0;
      cap_x      <= '0;
      cap_y      <= '0;
    end else begin
      ins_done_q <= 1'b0;
      case (state)
        SWEEP: sweep_idx <= (sweep_idx == LAST_I) ? '0 : sweep_idx + ONE_I;
        IDLE: begin
          if (bus.clear) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
          end else if (bus.ins_valid && full_w) begin
            overflow_q <= 1'b1;
          end else if (bus.ins_valid) begin
            cap_x <= bus.ins_x;
            cap_y <= bus.ins_y;
          end
        end
        WRITE: begin
          count_q    <= count_q + ONE_I;
          ins_done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_x[mem_waddr] <= mem_wx;
      mem_y[mem_waddr] <= mem_wy;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || (bus.rd_index >= DEPTH_I)) begin
      rd_x_q <= '1;
      rd_y_q <= '1;
    end else begin
      rd_x_q <= mem_x[bus.rd_index];
      rd_y_q <= mem_y[bus.rd_index];
    end
  end

  assign bus.ins_ready = ins_ready_w;
  assign bus.ins_done  = ins_done_q;
  assign bus.busy      = busy_w;
  assign bus.rd_x      = rd_x_q;
  assign bus.rd_y      = rd_y_q;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.overflow  = overflow_q;
endmodule
